seq_alu: RTL and testbench

Parametrised multi-cycle ALU for the processor datapath. It supports add, subtract, multiply and divide on WIDTH-bit unsigned operands, with a start/busy/done handshake. Multiply is iterative shift-add and divide is iterative restoring, so no wide combinational multiplier or divider is built. It produces a double-width result (low/high) and status flags, including divide-by-zero detection.

---
 rtl/seq_alu.sv | 204 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle add/sub, iterative shift-add multiply and
// restoring divide, with a start/busy/done handshake and registered result flags.
//
// state  | meaning
// IDLE   | waiting for start; busy=0
// MUL    | one multiplier bit per cycle, LSB first
// DIV    | one quotient bit per cycle, MSB first
// DONE   | one-cycle done pulse, results valid
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] ext,
  output logic             carry,
  output logic             zero,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   ext_q, ext_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               div0_q, div0_d;

  logic [WIDTH:0]     add_sum, sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_quo, div_rem;

  logic               fin;
  logic [WIDTH-1:0]   fin_out, fin_ext;
  logic               fin_carry, fin_div0;

  always_comb begin
    add_sum  = {1'b0, n1} + {1'b0, n2};
    sub_diff = {1'b0, n1} - {1'b0, n2};

    // Multiplicand lands in the upper half; the carry becomes the new top bit after the shift.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Dividend bits leave the top of acc_q while quotient bits enter at the bottom.
    div_trial = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, mcand_q};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_quo   = {acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    out_d     = out_q;
    ext_d     = ext_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    div0_d    = div0_q;
    fin       = 1'b0;
    fin_out   = '0;
    fin_ext   = '0;
    fin_carry = 1'b0;
    fin_div0  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD: begin
              fin       = 1'b1;
              fin_out   = add_sum[WIDTH-1:0];
              fin_carry = add_sum[WIDTH];
            end
            OP_SUB: begin
              fin       = 1'b1;
              fin_out   = sub_diff[WIDTH-1:0];
              fin_carry = sub_diff[WIDTH];
            end
            OP_MUL: begin
              state_d = S_MUL;
              cnt_d   = CW'(WIDTH);
              mcand_d = n2;
              acc_d   = {{WIDTH{1'b0}}, n1};
            end
            default: begin
              if (n2 == '0) begin
                fin      = 1'b1;
                fin_out  = '1;
                fin_ext  = n1;
                fin_div0 = 1'b1;
              end else begin
                state_d = S_DIV;
                cnt_d   = CW'(WIDTH);
                mcand_d = n2;
                acc_d   = {{WIDTH{1'b0}}, n1};
                rem_d   = '0;
              end
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          fin       = 1'b1;
          fin_out   = mul_next[WIDTH-1:0];
          fin_ext   = mul_next[2*WIDTH-1:WIDTH];
          fin_carry = (mul_next[2*WIDTH-1:WIDTH] != '0);
        end
      end
      S_DIV: begin
        acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo};
        rem_d = div_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          fin     = 1'b1;
          fin_out = div_quo;
          fin_ext = div_rem;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_DONE;
      out_d   = fin_out;
      ext_d   = fin_ext;
      carry_d = fin_carry;
      zero_d  = (fin_out == '0);
      div0_d  = fin_div0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      ext_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      ext_q   <= ext_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      div0_q  <= div0_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign out   = out_q;
  assign ext   = ext_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign div0  = div0_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=4): directed vector table, start-while-busy and
// mid-operation reset sequences, then random operations against an arithmetic model.
module tb_seq_alu;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] n1 = '0;
  logic [W-1:0] n2 = '0;
  logic         busy, done, carry, zero, div0;
  logic [W-1:0] out, ext;

  int n_checks = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .n1(n1), .n2(n2),
    .busy(busy), .done(done), .out(out), .ext(ext),
    .carry(carry), .zero(zero), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_out;
    logic [W-1:0] e_ext;
    logic         e_carry;
    logic         e_zero;
    logic         e_div0;
    int           lat;
    int           inject;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected result straight from integer arithmetic.
  function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    int   ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    v.op = o; v.a = a; v.b = b;
    v.e_ext = '0; v.e_carry = 1'b0; v.e_div0 = 1'b0; v.lat = 1; v.inject = -1;
    case (o)
      2'd0: begin r = ia + ib; v.e_out = W'(r % 16); v.e_carry = (r > 15); end
      2'd1: begin r = (ia - ib + 16) % 16; v.e_out = W'(r); v.e_carry = (ia < ib); end
      2'd2: begin
        r = ia * ib;
        v.e_out = W'(r % 16); v.e_ext = W'(r / 16); v.e_carry = (r / 16 != 0); v.lat = W + 1;
      end
      default: begin
        if (ib == 0) begin
          v.e_out = '1; v.e_ext = a; v.e_div0 = 1'b1;
        end else begin
          v.e_out = W'(ia / ib); v.e_ext = W'(ia % ib); v.lat = W + 1;
        end
      end
    endcase
    v.e_zero = (v.e_out == '0);
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    bit seen;
    @(negedge clk);
    check({tag, " busy_before_start"}, 32'(busy), 32'd0);
    check({tag, " done_before_start"}, 32'(done), 32'd0);
    start = 1'b1; op = v.op; n1 = v.a; n2 = v.b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); n1 = W'($urandom); n2 = W'($urandom);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == v.inject) begin
        start = 1'b1; op = 2'd2; n1 = 4'd3; n2 = 4'd3;
      end else begin
        start = 1'b0;
      end
      check({tag, " busy"}, 32'(busy), 32'd1);
      if (done) seen = 1;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(v.lat));
    check({tag, " out"}, 32'(out), 32'(v.e_out));
    check({tag, " ext"}, 32'(ext), 32'(v.e_ext));
    check({tag, " carry"}, 32'(carry), 32'(v.e_carry));
    check({tag, " zero"}, 32'(zero), 32'(v.e_zero));
    check({tag, " div0"}, 32'(div0), 32'(v.e_div0));
  endtask

  initial begin
    //           op     a      b      out    ext    c     z     d0    lat inject
    tbl[0]  = '{2'd0, 4'd9,  4'd8,  4'd1,  4'd0,  1'b1, 1'b0, 1'b0, 1, -1};
    tbl[1]  = '{2'd1, 4'd3,  4'd5,  4'd14, 4'd0,  1'b1, 1'b0, 1'b0, 1, -1};
    tbl[2]  = '{2'd1, 4'd5,  4'd5,  4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1, -1};
    tbl[3]  = '{2'd2, 4'd13, 4'd11, 4'hF,  4'h8,  1'b1, 1'b0, 1'b0, 5, -1};
    tbl[4]  = '{2'd3, 4'd13, 4'd4,  4'd3,  4'd1,  1'b0, 1'b0, 1'b0, 5, 2};
    tbl[5]  = '{2'd3, 4'd7,  4'd0,  4'd15, 4'd7,  1'b0, 1'b0, 1'b1, 1, -1};
    tbl[6]  = '{2'd0, 4'd0,  4'd0,  4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 1, -1};
    tbl[7]  = '{2'd2, 4'd0,  4'd5,  4'd0,  4'd0,  1'b0, 1'b1, 1'b0, 5, -1};
    tbl[8]  = '{2'd2, 4'd15, 4'd15, 4'h1,  4'hE,  1'b1, 1'b0, 1'b0, 5, -1};
    tbl[9]  = '{2'd3, 4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 1'b0, 1'b0, 5, -1};
    tbl[10] = '{2'd3, 4'd2,  4'd9,  4'd0,  4'd2,  1'b0, 1'b1, 1'b0, 5, -1};
    tbl[11] = '{2'd0, 4'd15, 4'd1,  4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 1, -1};
    tbl[12] = '{2'd1, 4'd0,  4'd15, 4'd1,  4'd0,  1'b1, 1'b0, 1'b0, 1, -1};
    tbl[13] = '{2'd2, 4'd3,  4'd5,  4'hF,  4'h0,  1'b0, 1'b0, 1'b0, 5, -1};
    tbl[14] = '{2'd3, 4'd7,  4'd0,  4'd15, 4'd7,  1'b0, 1'b0, 1'b1, 1, -1};

    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset out", 32'(out), 32'd0);
    check("reset ext", 32'(ext), 32'd0);
    check("reset flags", 32'({carry, zero, div0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Abort a 15*15 multiply two cycles in; outputs (div0=1, out=F) must clear at once.
    @(negedge clk);
    start = 1'b1; op = 2'd2; n1 = 4'd15; n2 = 4'd15;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort out", 32'(out), 32'd0);
    check("abort ext", 32'(ext), 32'd0);
    check("abort flags", 32'({carry, zero, div0}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort no_done", 32'(done), 32'd0);
    end
    run_op(model(2'd0, 4'd1, 4'd1), "post_reset add");

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      logic [1:0]   o;
      logic [W-1:0] a, b;
      o = 2'($urandom);
      a = W'($urandom);
      b = (($urandom % 6) == 0) ? '0 : W'($urandom);
      v = model(o, a, b);
      run_op(v, $sformatf("rand%0d op%0d %0d,%0d", i, o, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
